// File: rtl/elevator_car_ctrl.sv
// Single-car SCAN elevator controller: serves latched per-floor requests, door timing, direction preference.
// Optional macro ELEV_IDLE_HOME_EN: after HOME_CYCLES idle cycles the car returns to floor 0 with the door closed.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int HOME_CYCLES   = 64
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_FLOORS-1:0]         floor_req,
  output logic [NUM_FLOORS-1:0]         done,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic                          moving_up,
  output logic                          moving_down,
  output logic                          door_open
);

  localparam int FW = $clog2(NUM_FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES);
  // The cycle in which a re-request is seen already counts toward the new window.
  localparam logic [DW-1:0] DOOR_RELOAD = DW'(DOOR_CYCLES - 1);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16) begin : g_bad_floors
    $error("NUM_FLOORS out of range");
  end
  if (TRAVEL_CYCLES < 1 || DOOR_CYCLES < 1) begin : g_bad_timing
    $error("TRAVEL_CYCLES and DOOR_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t          state;
  logic            dir_up;
  logic [TW-1:0]   travel_cnt;
  logic [DW-1:0]   door_cnt;
  logic [FW-1:0]   step_floor;
  logic            req_here, req_above, req_below;
  logic            req_step, step_above, step_below;
  logic            idle_up;

`ifdef ELEV_IDLE_HOME_EN
  localparam int HW = $clog2(HOME_CYCLES + 1);
  logic [HW-1:0] idle_cnt;
  logic          homing;
  logic          home_cond;
  assign home_cond = (floor_req == '0) && (cur_floor != '0);
`else
  if (HOME_CYCLES < 1) begin : g_bad_home
    $error("HOME_CYCLES must be >= 1");
  end
`endif

  // Request summaries relative to the current floor and to the floor being approached.
  always_comb begin
    step_floor = (state == MOVE_DOWN) ? cur_floor - 1'b1 : cur_floor + 1'b1;
    req_here   = 1'b0;
    req_above  = 1'b0;
    req_below  = 1'b0;
    req_step   = 1'b0;
    step_above = 1'b0;
    step_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_req[i]) begin
        if (FW'(i) == cur_floor)  req_here   = 1'b1;
        if (FW'(i) >  cur_floor)  req_above  = 1'b1;
        if (FW'(i) <  cur_floor)  req_below  = 1'b1;
        if (FW'(i) == step_floor) req_step   = 1'b1;
        if (FW'(i) >  step_floor) step_above = 1'b1;
        if (FW'(i) <  step_floor) step_below = 1'b1;
      end
    end
    idle_up = req_above && (dir_up || !req_below);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      travel_cnt <= '0;
      door_cnt   <= '0;
`ifdef ELEV_IDLE_HOME_EN
      idle_cnt   <= '0;
      homing     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef ELEV_IDLE_HOME_EN
          idle_cnt <= home_cond ? idle_cnt + 1'b1 : '0;
`endif
          if (req_here) begin
            state    <= DOOR_OPEN;
            door_cnt <= DOOR_LOAD;
          end else if (req_above || req_below) begin
            state      <= idle_up ? MOVE_UP : MOVE_DOWN;
            dir_up     <= idle_up;
            travel_cnt <= TRAVEL_LOAD;
`ifdef ELEV_IDLE_HOME_EN
          end else if (home_cond && idle_cnt >= HW'(HOME_CYCLES - 1)) begin
            state      <= MOVE_DOWN;
            dir_up     <= 1'b0;
            travel_cnt <= TRAVEL_LOAD;
            homing     <= 1'b1;
            idle_cnt   <= '0;
`endif
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (travel_cnt > TW'(1)) begin
            travel_cnt <= travel_cnt - 1'b1;
          end else begin
            cur_floor  <= step_floor;
            travel_cnt <= '0;
            if (req_step) begin
              state    <= DOOR_OPEN;
              door_cnt <= DOOR_LOAD;
`ifdef ELEV_IDLE_HOME_EN
              homing   <= 1'b0;
`endif
            end else if (state == MOVE_UP ? step_above : step_below) begin
              travel_cnt <= TRAVEL_LOAD;
`ifdef ELEV_IDLE_HOME_EN
            end else if (homing && step_floor != '0) begin
              travel_cnt <= TRAVEL_LOAD;
`endif
            end else begin
              state <= IDLE;
`ifdef ELEV_IDLE_HOME_EN
              homing <= 1'b0;
`endif
            end
          end
        end
        DOOR_OPEN: begin
          if (req_here) begin
            door_cnt <= DOOR_RELOAD;
          end else if (door_cnt <= DW'(1)) begin
            state    <= IDLE;
            door_cnt <= '0;
          end else begin
            door_cnt <= door_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign moving_up   = (state == MOVE_UP);
  assign moving_down = (state == MOVE_DOWN);
  assign door_open   = (state == DOOR_OPEN);

  always_comb begin
    done = '0;
    if (state == DOOR_OPEN) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (FW'(i) == cur_floor) done[i] = floor_req[i];
      end
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Randomized scoreboard bench for elevator_car_ctrl: an event-time reference model predicts every cycle's outputs.
module tb_elevator_car_ctrl;
  localparam int NF = 4;
  localparam int TC = 8;
  localparam int DC = 16;
  localparam int FW = $clog2(NF);

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [NF-1:0] floor_req = '0;
  logic [NF-1:0] done;
  logic [FW-1:0] cur_floor;
  logic          moving_up, moving_down, door_open;

  elevator_car_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .HOME_CYCLES(64)) dut (
    .Clock(Clock), .Reset(Reset), .floor_req(floor_req), .done(done),
    .cur_floor(cur_floor), .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [NF-1:0] done;
    logic [FW-1:0] floor;
    logic          up, down, door;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model: car position plus absolute edge numbers of the next arrival / door close.
  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
  mode_t         m_mode    = M_IDLE;
  int            m_floor   = 0;
  bit            m_dirup   = 1'b1;
  int            edge_n    = 0;
  int            arrive_at = 0;
  int            close_at  = 0;
  logic [NF-1:0] m_done    = '0;

  function automatic bit any_req(input logic [NF-1:0] r, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < NF && r[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic [NF-1:0] r, input logic rst);
    bit ab, be, further;
    edge_n++;
    if (rst) begin
      m_mode = M_IDLE; m_floor = 0; m_dirup = 1'b1;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        ab = any_req(r, m_floor + 1, NF - 1);
        be = any_req(r, 0, m_floor - 1);
        if (r[m_floor]) begin
          m_mode = M_DOOR; close_at = edge_n + DC;
        end else if (ab || be) begin
          m_dirup   = ab && (m_dirup || !be);
          m_mode    = m_dirup ? M_UP : M_DOWN;
          arrive_at = edge_n + TC;
        end
      end
      M_DOOR: begin
        if (r[m_floor]) close_at = edge_n + DC - 1;
        else if (edge_n >= close_at) m_mode = M_IDLE;
      end
      default: begin
        if (edge_n == arrive_at) begin
          m_floor += (m_mode == M_UP) ? 1 : -1;
          further = (m_mode == M_UP) ? any_req(r, m_floor + 1, NF - 1) : any_req(r, 0, m_floor - 1);
          if (r[m_floor]) begin
            m_mode = M_DOOR; close_at = edge_n + DC;
          end else if (further) arrive_at = edge_n + TC;
          else m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  function automatic obs_t model_out(input logic [NF-1:0] r);
    obs_t o;
    o.floor = FW'(m_floor);
    o.up    = (m_mode == M_UP);
    o.down  = (m_mode == M_DOWN);
    o.door  = (m_mode == M_DOOR);
    o.done  = '0;
    if (o.door) o.done[m_floor] = r[m_floor];
    return o;
  endfunction

  // One clock: advance model on the edge, requester drops served bits and adds new ones, push expectation.
  task automatic cycle(input logic rst, input logic [NF-1:0] add);
    @(posedge Clock); #1;
    cyc++;
    model_edge(floor_req, Reset);
    floor_req = (floor_req & ~m_done) | (add & ~m_done);
    Reset     = rst;
    exp_q.push_back(model_out(floor_req));
    m_done    = model_out(floor_req).done;
  endtask

  task automatic run_until(input int fl, input mode_t md, input int budget);
    for (int k = 0; k < budget && !(m_floor == fl && m_mode == md); k++) cycle(1'b0, '0);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  always @(negedge Clock) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cur_floor",   int'(cur_floor),   int'(e.floor));
      chk("moving_up",   int'(moving_up),   int'(e.up));
      chk("moving_down", int'(moving_down), int'(e.down));
      chk("door_open",   int'(door_open),   int'(e.door));
      chk("done",        int'(done),        int'(e.done));
      chk("dir_exclusive", int'(moving_up & moving_down), 0);
    end
  end

  initial begin
    logic [NF-1:0] add;
    logic [NF-1:0] r0001, r0100, r1000;
    r0001 = NF'(1); r0100 = NF'(4); r1000 = NF'(8);
    cycle(1'b1, '0);
    cycle(1'b0, '0);
    // Open at floor 0, then full trip to the top.
    cycle(1'b0, r0001); repeat (24) cycle(1'b0, '0);
    cycle(1'b0, r1000); repeat (50) cycle(1'b0, '0);
    cycle(1'b0, r0001); repeat (50) cycle(1'b0, '0);
    // Mid-travel request for floor 2 while heading to 3.
    cycle(1'b0, r1000); repeat (3) cycle(1'b0, '0);
    cycle(1'b0, r0100); repeat (80) cycle(1'b0, '0);
    cycle(1'b0, r0001); repeat (50) cycle(1'b0, '0);
    // Request below while passing floor 1 upward: top served first.
    cycle(1'b0, r1000); run_until(1, M_UP, 40);
    cycle(1'b0, r0001); repeat (100) cycle(1'b0, '0);
    // Door re-request after 10 open cycles at floor 2.
    cycle(1'b0, r0100); run_until(2, M_DOOR, 60);
    repeat (10) cycle(1'b0, '0);
    cycle(1'b0, r0100); repeat (30) cycle(1'b0, '0);
    // Reset while moving up out of floor 2.
    cycle(1'b0, r1000); run_until(2, M_UP, 60);
    repeat (3) cycle(1'b0, '0);
    cycle(1'b1, '0); cycle(1'b0, '0);
    repeat (40) cycle(1'b0, '0);
    // Random traffic with occasional resets and quiet stretches.
    for (int n = 0; n < 4000; n++) begin
      add = '0;
      if ((n / 500) % 2 == 0 || $urandom_range(0, 3) == 0)
        for (int i = 0; i < NF; i++) add[i] = ($urandom_range(0, 40) == 0);
      cycle($urandom_range(0, 700) == 0, add);
    end
    repeat (2) @(posedge Clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors (2..16).
REQ-002 Parameter TRAVEL_CYCLES, default 8, clock cycles to move one floor (>=1).
REQ-003 Parameter DOOR_CYCLES, default 16, clock cycles door stays open (>=1).
REQ-004 Parameter HOME_CYCLES, default 64, idle cycles before homing (used only with ELEV_IDLE_HOME_EN).
REQ-005 Clock  input  1  clock; all state changes on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 floor_req  input  NUM_FLOORS  per-floor latched request flags; bit i held high until done[i].
REQ-008 done  output  NUM_FLOORS  per-floor service acknowledge; requester clears bit i on it.
REQ-009 cur_floor  output  clog2(NUM_FLOORS)  current car floor, 0 = bottom.
REQ-010 moving_up / moving_down  output  1 each  car travelling; never both high.
REQ-011 door_open  output  1  car stopped with door open.

Function
REQ-012 Block SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; moving_up/moving_down/door_open are decodes of state.
REQ-013 Block SHALL keep a direction-preference bit dir_up (reset 1), updated to the direction of every move started.
REQ-014 IDLE: floor_req[cur_floor] -> DOOR_OPEN; else request above/below exists -> move in dir_up direction if requests lie that way, otherwise opposite; else stay IDLE.
REQ-015 MOVE_*: travel counter SHALL count TRAVEL_CYCLES cycles, then cur_floor SHALL step +1/-1 on the same edge the counter expires.
REQ-016 On arrival: floor_req[new floor] -> DOOR_OPEN; else requests further in current direction -> continue moving (counter restarts); else -> IDLE.
REQ-017 Requests asserted mid-travel SHALL be honoured at the next arrival; car SHALL NOT reverse before arriving at a floor.
REQ-018 done[i] SHALL be combinational: high iff state==DOOR_OPEN, cur_floor==i, floor_req[i]==1; all other bits 0.
REQ-019 DOOR_OPEN: door timer loads DOOR_CYCLES on entry; leaves to IDLE evaluation after DOOR_CYCLES cycles.
REQ-020 floor_req[cur_floor] asserted while DOOR_OPEN SHALL reload the door timer and produce done[cur_floor].
REQ-021 Car SHALL never step above NUM_FLOORS-1 or below 0; request bits at or beyond NUM_FLOORS ignored.
REQ-022 Simultaneous requests above and below in IDLE SHALL resolve by dir_up (SCAN order).

Reset
REQ-023 Reset SHALL force state IDLE, cur_floor 0, dir_up 1, all counters 0, door_open 0, moving_up 0, moving_down 0, done 0.
REQ-024 Reset asserted mid-travel or mid-door SHALL abort the operation on that edge; car snaps to floor 0, no done pulse issued.

Configuration
REQ-025 Macro ELEV_IDLE_HOME_EN defined: after HOME_CYCLES consecutive IDLE cycles with floor_req==0 and cur_floor!=0, car SHALL move down to floor 0 and enter IDLE there without opening door; any request during homing is served by normal REQ-016 rules.
REQ-026 Macro ELEV_IDLE_HOME_EN undefined: idle counter absent; car stays at cur_floor indefinitely when idle.

Verification
REQ-027 Reset, floor_req=0001 at floor 0 -> next cycle door_open=1, done=0001 for exactly one cycle once requester clears, door_open lasts 16 cycles.
REQ-028 Floor 0 idle, floor_req=1000 -> moving_up=1, cur_floor 1,2,3 at 8-cycle intervals, door_open at floor 3, done[3] pulse, then IDLE.
REQ-029 Moving up between 0 and 1 with 1000 pending, assert 0100 -> car stops at floor 2 (done[2]), resumes up to floor 3.
REQ-030 At floor 1 moving up toward 3, assert 0001 -> floor 3 served first, then car returns down to floor 0 and services it.
REQ-031 Door open at floor 2 for 10 cycles, re-assert floor_req[2] -> done[2] pulse, door open 16 further cycles.
REQ-032 Reset during MOVE_UP from floor 2 -> next cycle cur_floor=0, IDLE, all outputs 0; with ELEV_IDLE_HOME_EN, idle at floor 3 for 64 cycles -> car descends to 0, door stays closed.
